// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   inst_addr_t / inst_t : 32-bit instruction address and word
//   fetch_entry_t        : {pc, inst} pair held in the prefetch FIFO
//   if_state_e           : fetch request FSM encoding
package if_fetch_unit_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD  = '0;
  localparam inst_addr_t IF_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,   // no request outstanding
    IF_BUSY = 2'd1,   // request outstanding, data will be kept
    IF_DROP = 2'd2    // request outstanding, data will be discarded
  } if_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic inst_addr_t word_align(input inst_addr_t a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} entries.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail
//   pop/dout : dout is the head entry (combinational), pop advances it
//   clear    : empty the FIFO (pointers and count)
//   count    : number of valid entries; the only status output
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; only count decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage.
// Keeps the fetch PC, issues one outstanding req/ack read at a time to
// instruction memory, buffers returned words in a prefetch FIFO and drives
// the registered IF/ID outputs toward decode.
//   clk, rst       : clock, synchronous active-high reset
//   stall_i        : decode stall, hold if_* outputs and do not pop
//   flush_i        : redirect, discard FIFO, in-flight data and outputs
//   new_pc_i       : redirect target (low two bits ignored)
//   imem_req_o     : registered read request, held until the ack cycle
//   imem_addr_o    : registered word address, stable while req is high
//   imem_ack_i     : read complete, imem_rdata_i valid this cycle
//   imem_rdata_i   : instruction word
//   if_pc_o        : PC of if_inst_o
//   if_inst_o      : instruction to decode, zero (NOP) when not valid
//   if_valid_o     : if_inst_o holds a fetched instruction
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if_state_e        state, state_n;
  inst_addr_t       fetch_pc, fetch_pc_n, addr_n;
  logic             push, pop, has_room;
  logic [CNT_W-1:0] count, count_n;
  fetch_entry_t     fifo_din, fifo_dout;

  // Only a BUSY ack keeps its data; DROP acks and flushed acks are discarded.
  assign push     = (state == IF_BUSY) && imem_ack_i && !flush_i;
  assign pop      = !flush_i && !stall_i && (count != '0);
  assign count_n  = count + CNT_W'(push) - CNT_W'(pop);
  // A new request is only issued when its data is guaranteed a slot.
  assign has_room = count_n < CNT_W'(FIFO_DEPTH);
  assign fifo_din = '{pc: fetch_pc, inst: imem_rdata_i};

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_i),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = imem_addr_o;
    case (state)
      IF_IDLE: begin
        if (flush_i)       fetch_pc_n = word_align(new_pc_i);
        else if (has_room) state_n    = IF_BUSY;
      end
      IF_BUSY: begin
        if (flush_i) begin
          fetch_pc_n = word_align(new_pc_i);
          // Without the ack the request is still live and must run to completion.
          state_n    = imem_ack_i ? IF_IDLE : IF_DROP;
        end else if (imem_ack_i) begin
          fetch_pc_n = fetch_pc + IF_PC_STEP;
          state_n    = has_room ? IF_BUSY : IF_IDLE;
        end
      end
      IF_DROP: begin
        if (flush_i)    fetch_pc_n = word_align(new_pc_i);
        if (imem_ack_i) state_n    = IF_IDLE;
      end
      default: state_n = IF_IDLE;
    endcase
    // Address only moves when a fresh request is launched; in BUSY without an
    // ack fetch_pc_n equals the current address, and DROP keeps the old one.
    if (state_n == IF_BUSY) addr_n = fetch_pc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IF_IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      imem_req_o  <= (state_n != IF_IDLE);
      imem_addr_o <= addr_n;
    end
  end

  // IF/ID register: flush beats stall, stall beats pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= ZERO_WORD;
    end else if (!stall_i) begin
      if (count != '0) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= fifo_dout.pc;
        if_inst_o  <= fifo_dout.inst;
      end else begin
        if_valid_o <= 1'b0;
        if_inst_o  <= ZERO_WORD;
      end
    end
  end

endmodule
